// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame scheduler: default SOF byte, FSM and phase encodings.
// Also holds a small helper for cyclic index advance.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h7E;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_FETCH   = 3'd4;

    localparam logic [1:0] PH_SOF  = 2'd0;
    localparam logic [1:0] PH_ID   = 2'd1;
    localparam logic [1:0] PH_PAY  = 2'd2;
    localparam logic [1:0] PH_CSUM = 2'd3;

    // Next index after idx, wrapping to 0 once it reaches n.
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
        logic [3:0] nxt;
        nxt = {1'b0, idx} + 4'd1;
        return (nxt >= 4'(n)) ? 3'd0 : nxt[2:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, searching cyclically.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_idx
);

    logic [7:0] req_ext;
    logic [7:0] grant_ext;
    logic [3:0] cand;
    logic       found;

    assign req_ext = 8'(req);
    assign grant   = grant_ext[NUM_REQ-1:0];

    always_comb begin
        grant_ext = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!found && req_ext[cand[2:0]]) begin
                found     = 1'b1;
                grant_idx = cand[2:0];
            end
        end
        grant_ext[grant_idx] = found;
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one uart_tx between NUM_REQ sources; each grant emits SOF, channel ID, payload, XOR checksum.
module uart_frame_scheduler #(
    parameter int         NUM_REQ  = 4,
    parameter int         MAX_LEN  = 64,
    parameter logic [7:0] SOF_BYTE = uart_frame_pkg::SOF_BYTE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [2:0]             grant_id,
    output logic                   frame_active,
    output logic                   frame_done,
    output logic                   len_overflow
);
    import uart_frame_pkg::*;

    localparam int            CW      = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

    logic [2:0]         state;
    logic [1:0]         phase;
    logic [2:0]         rr_ptr;
    logic [7:0]         csum;
    logic [CW-1:0]      count;
    logic               last_seen;

    logic [NUM_REQ-1:0] arb_grant;
    logic [2:0]         arb_idx;
    logic [7:0]         valid_ext;
    logic [7:0]         last_ext;
    logic [63:0]        data_ext;
    logic [7:0]         grant_mask;
    logic [7:0]         fetch_byte;
    logic               fetch_ok;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Widen the request buses so grant_id can index them for any NUM_REQ up to 8.
    assign valid_ext  = 8'(req_valid);
    assign last_ext   = 8'(req_last);
    assign data_ext   = 64'(req_data);
    assign grant_mask = 8'd1 << grant_id;
    assign fetch_byte = data_ext[{grant_id, 3'b000} +: 8];
    assign fetch_ok   = (state == ST_FETCH) && valid_ext[grant_id];
    assign req_ready  = fetch_ok ? grant_mask[NUM_REQ-1:0] : '0;
    assign tx_start   = (state == ST_LAUNCH) && !tx_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            phase        <= PH_SOF;
            rr_ptr       <= '0;
            csum         <= '0;
            count        <= '0;
            last_seen    <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            len_overflow <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            len_overflow <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count     <= '0;
                    last_seen <= 1'b0;
                    if (|arb_grant) begin
                        grant_id     <= arb_idx;
                        tx_data      <= SOF_BYTE;
                        phase        <= PH_SOF;
                        frame_active <= 1'b1;
                        state        <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (!tx_busy) begin
                        state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        case (phase)
                            PH_SOF: begin
                                tx_data <= {5'b0, grant_id};
                                csum    <= {5'b0, grant_id};
                                phase   <= PH_ID;
                                state   <= ST_LAUNCH;
                            end
                            PH_ID: begin
                                state <= ST_FETCH;
                            end
                            PH_PAY: begin
                                // Hitting MAX_LEN without a last flag closes the frame early.
                                if (last_seen || count == MAX_CNT) begin
                                    tx_data      <= csum;
                                    phase        <= PH_CSUM;
                                    len_overflow <= !last_seen;
                                    state        <= ST_LAUNCH;
                                end else begin
                                    state <= ST_FETCH;
                                end
                            end
                            default: begin
                                frame_done   <= 1'b1;
                                frame_active <= 1'b0;
                                rr_ptr       <= wrap_inc(grant_id, NUM_REQ);
                                state        <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_FETCH: begin
                    if (fetch_ok) begin
                        tx_data   <= fetch_byte;
                        csum      <= csum ^ fetch_byte;
                        count     <= count + CW'(1);
                        last_seen <= last_ext[grant_id];
                        phase     <= PH_PAY;
                        state     <= ST_LAUNCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a behavioural byte transmitter and queued sources.
module tb_uart_frame_scheduler;

    localparam int NUM_REQ = 4;
    localparam int MAX_LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        frame_active;
    logic        frame_done;
    logic        len_overflow;

    int checks = 0;
    int errors = 0;

    logic [8:0] src_q [4][$];
    logic [7:0] line_q[$];
    logic [7:0] exp_q[$];
    logic [2:0] grant_q[$];
    int         ready_cnt [4];
    int         done_cnt, ovf_cnt, start_cnt, stab_err, onehot_err, busy_cnt;
    logic [7:0] ovf_data, cur_byte;
    logic       fa_d;

    always #5 clk = ~clk;

    uart_frame_scheduler #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN), .SOF_BYTE(8'h7E)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .len_overflow (len_overflow)
    );

    // Byte transmitter stand-in: busy rises the cycle after start and lasts 8 cycles.
    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start) begin
            line_q.push_back(tx_data);
            cur_byte <= tx_data;
            busy_cnt <= 8;
            start_cnt++;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) begin
                ready_cnt[i]++;
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
        end
    end

    // Sources present their queue heads; monitors sample DUT outputs away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]       = src_q[i][0][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        if (frame_done) done_cnt++;
        if (len_overflow) begin
            ovf_cnt++;
            ovf_data = tx_data;
        end
        if (tx_busy && frame_active && tx_data != cur_byte) stab_err++;
        if (req_ready != 4'b0 && req_ready != (4'b1 << grant_id)) onehot_err++;
        if (frame_active && !fa_d) grant_q.push_back(grant_id);
        fa_d = frame_active;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] b, input logic last);
        src_q[ch].push_back({last, b});
    endtask

    task automatic expWord(input logic [63:0] w, input int n);
        for (int k = n - 1; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
    endtask

    task automatic clearLogs();
        line_q.delete();
        exp_q.delete();
        grant_q.delete();
        for (int i = 0; i < 4; i++) ready_cnt[i] = 0;
        done_cnt = 0;
        ovf_cnt  = 0;
        ovf_data = 8'h00;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) src_q[i].delete();
        clearLogs();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int idle = 0;
        for (int c = 0; c < budget && idle < 4; c++) begin
            @(negedge clk);
            if (!frame_active && !tx_busy && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && src_q[3].size() == 0) idle++;
            else idle = 0;
        end
        if (idle < 4) checkOutput({tag, "_idle_timeout"}, 1, 0);
    endtask

    task automatic waitReady(input string tag, input int ch, input int n, input int budget);
        int c = 0;
        while (ready_cnt[ch] < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (ready_cnt[ch] < n) checkOutput({tag, "_ready_timeout"}, 1, 0);
    endtask

    task automatic compareLine(input string tag);
        checkOutput({tag, "_len"}, line_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < line_q.size()) checkOutput($sformatf("%s_b%0d", tag, i), line_q[i], exp_q[i]);
        end
    endtask

    initial begin
        busy_cnt = 0; start_cnt = 0; stab_err = 0; onehot_err = 0; fa_d = 1'b0; cur_byte = 8'h00;
        clearLogs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {tx_start, req_ready, tx_data, grant_id, frame_active, frame_done, len_overflow}, 0);
        doReset();

        // 1: single frame, csum 00^11^22 = 33
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h22, 1'b1);
        waitIdle("t1", 400);
        expWord(64'h7E_00_11_22_33, 5);
        compareLine("t1_line");
        checkOutput("t1_done", done_cnt, 1);
        checkOutput("t1_ready0", ready_cnt[0], 2);
        checkOutput("t1_ovf", ovf_cnt, 0);

        // 2: req1 and req3 together, then req0/req1 together shows rr_ptr wrapped to 0
        doReset();
        applyStimulus(1, 8'hA1, 1'b1);
        applyStimulus(3, 8'hB3, 1'b1);
        waitIdle("t2a", 600);
        applyStimulus(0, 8'hE0, 1'b1);
        applyStimulus(1, 8'hE1, 1'b1);
        waitIdle("t2b", 600);
        expWord(64'h7E_01_A1_A0_7E_03_B3_B0, 8);
        expWord(64'h7E_00_E0_E0_7E_01_E1_E0, 8);
        compareLine("t2_line");
        checkOutput("t2_ngrants", grant_q.size(), 4);
        checkOutput("t2_g0", grant_q.size() > 0 ? grant_q[0] : 3'd7, 1);
        checkOutput("t2_g1", grant_q.size() > 1 ? grant_q[1] : 3'd7, 3);
        checkOutput("t2_g2", grant_q.size() > 2 ? grant_q[2] : 3'd7, 0);
        checkOutput("t2_g3", grant_q.size() > 3 ? grant_q[3] : 3'd7, 1);

        // 3: req2 holds valid over three frames, req0 over two -> 0,2,0,2,2
        doReset();
        applyStimulus(0, 8'hC0, 1'b1);
        applyStimulus(0, 8'hC1, 1'b1);
        applyStimulus(2, 8'hD0, 1'b1);
        applyStimulus(2, 8'hD1, 1'b1);
        applyStimulus(2, 8'hD2, 1'b1);
        waitIdle("t3", 1500);
        expWord(64'h7E_00_C0_C0_7E_02_D0_D2, 8);
        expWord(64'h7E_00_C1_C1_7E_02_D1_D3, 8);
        expWord(64'h7E_02_D2_D0, 4);
        compareLine("t3_line");
        checkOutput("t3_ngrants", grant_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_g%0d", i), grant_q.size() > i ? grant_q[i] : 3'd7,
                        (i % 2 == 1 || i == 4) ? 2 : 0);
        end

        // 4: MAX_LEN=4 force-close; csum 00^01^02^03^04 = 04, then 05^06 = 03
        doReset();
        for (int b = 1; b <= 6; b++) applyStimulus(0, 8'(b), b == 6);
        waitIdle("t4", 1500);
        expWord(64'h7E_00_01_02_03_04_04, 7);
        expWord(64'h7E_00_05_06_03, 5);
        compareLine("t4_line");
        checkOutput("t4_ovf_cnt", ovf_cnt, 1);
        checkOutput("t4_ovf_data", ovf_data, 8'h04);
        checkOutput("t4_done", done_cnt, 2);
        checkOutput("t4_ready0", ready_cnt[0], 6);

        // 5: source starves mid-frame; csum 00^31^32^33 = 30
        doReset();
        applyStimulus(0, 8'h31, 1'b0);
        waitReady("t5", 0, 1, 400);
        repeat (16) @(negedge clk);
        begin
            int s;
            s = start_cnt;
            repeat (20) @(negedge clk);
            checkOutput("t5_stall_starts", start_cnt - s, 0);
            checkOutput("t5_stall_active", frame_active, 1);
        end
        applyStimulus(0, 8'h32, 1'b0);
        applyStimulus(0, 8'h33, 1'b1);
        waitIdle("t5", 600);
        expWord(64'h7E_00_31_32_33_30, 6);
        compareLine("t5_line");
        checkOutput("t5_ready0", ready_cnt[0], 3);

        // 6: reset while payload byte 2 is pending, then a clean frame
        doReset();
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b1);
        waitReady("t6", 0, 2, 600);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_reset_outputs",
                    {tx_start, req_ready, tx_data, grant_id, frame_active, frame_done, len_overflow}, 0);
        doReset();
        applyStimulus(0, 8'h51, 1'b1);
        waitIdle("t6", 400);
        expWord(64'h7E_00_51_51, 4);
        compareLine("t6_line");
        checkOutput("t6_done", done_cnt, 1);

        checkOutput("tx_data_stable", stab_err, 0);
        checkOutput("req_ready_onehot", onehot_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
